// File: rtl/pc_sequencer.sv
// Instruction fetch and PC sequencer: fetches one word per instruction over a req/ready
// handshake, presents it to decode, and selects the next PC from control_unit decisions.
module pc_sequencer #(
  parameter logic [31:0] RESET_PC      = 32'h0000_0000,
  parameter int unsigned FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_b,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic        inst_valid,
  input  logic        ctl_halted,
  input  logic        ctl_branch,
  input  logic        ctl_jump,
  input  logic        ctl_jump_register,
  input  logic [31:0] rs_data,
  input  logic        stall,
  output logic [31:0] pc,
  output logic        halted,
  output logic        fetch_timeout
);

  localparam int unsigned CntW = $clog2(FETCH_TIMEOUT + 1);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StHalt, StError} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [31:0]     inst_q, inst_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            req_q, req_d;
  logic            valid_q, valid_d;
  logic            halted_q, halted_d;
  logic            tmo_q, tmo_d;
  logic [31:0]     pc4;
  logic [31:0]     br_off;

  assign pc4    = pc_q + 32'd4;
  assign br_off = {{14{inst_q[15]}}, inst_q[15:0], 2'b00};

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q  <= StIdle;
      pc_q     <= RESET_PC;
      inst_q   <= '0;
      cnt_q    <= '0;
      req_q    <= 1'b0;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
      tmo_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      inst_q   <= inst_d;
      cnt_q    <= cnt_d;
      req_q    <= req_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
      tmo_q    <= tmo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: state_d = StFetch;
      StFetch: begin
        // Ready in the final wait cycle still completes the fetch.
        if (imem_ready) begin
          inst_d  = imem_rdata;
          cnt_d   = '0;
          state_d = StExec;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (cnt_d == CntW'(FETCH_TIMEOUT)) state_d = StError;
        end
      end
      StExec: begin
        if (!stall) begin
          state_d = StFetch;
          if (ctl_halted)             state_d = StHalt;
          else if (ctl_jump_register) pc_d = {rs_data[31:2], 2'b00};
          else if (ctl_jump)          pc_d = {pc4[31:28], inst_q[25:0], 2'b00};
          else if (ctl_branch)        pc_d = pc4 + br_off;
          else                        pc_d = pc4;
        end
      end
      StHalt, StError: ;
      default: state_d = StIdle;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    req_d    = (state_d == StFetch);
    valid_d  = (state_d == StExec);
    halted_d = (state_d == StHalt);
    tmo_d    = (state_d == StError);
  end

  assign imem_req      = req_q;
  assign imem_addr     = pc_q;
  assign inst          = inst_q;
  assign inst_valid    = valid_q;
  assign pc            = pc_q;
  assign halted        = halted_q;
  assign fetch_timeout = tmo_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench for pc_sequencer: expected fetch addresses are queued by the stimulus
// and checked by a monitor on every new fetch request.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_b = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] inst;
  logic        inst_valid;
  logic        ctl_halted = 1'b0;
  logic        ctl_branch = 1'b0;
  logic        ctl_jump = 1'b0;
  logic        ctl_jump_register = 1'b0;
  logic [31:0] rs_data = '0;
  logic        stall = 1'b0;
  logic [31:0] pc;
  logic        halted;
  logic        fetch_timeout;

  int          tot = 0;
  int          bad = 0;
  logic [31:0] exp_q[$];
  logic        req_prev = 1'b0;
  logic [31:0] mon_exp;

  always #5 clk = ~clk;

  pc_sequencer dut (
    .clk              (clk),
    .rst_b            (rst_b),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .inst             (inst),
    .inst_valid       (inst_valid),
    .ctl_halted       (ctl_halted),
    .ctl_branch       (ctl_branch),
    .ctl_jump         (ctl_jump),
    .ctl_jump_register(ctl_jump_register),
    .rs_data          (rs_data),
    .stall            (stall),
    .pc               (pc),
    .halted           (halted),
    .fetch_timeout    (fetch_timeout)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tot++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %08h want %08h", name, act, exp);
    end
  endtask

  // Monitor: each new fetch request must match the next queued address.
  always @(negedge clk) begin
    if (imem_req && !req_prev) begin
      if (exp_q.size() == 0) begin
        tot++;
        bad++;
        $display("FAIL unexpected_fetch: got %08h want none", imem_addr);
      end else begin
        mon_exp = exp_q.pop_front();
        chk("fetch_addr", imem_addr, mon_exp);
        chk("pc_eq_addr", pc, imem_addr);
      end
    end
    req_prev <= imem_req;
  end

  // ctl = {halted, jump_register, jump, branch}
  task automatic exec_instr(input logic [31:0] word, input logic [3:0] ctl,
                            input logic [31:0] rs, input logic [31:0] nxt,
                            input int dly, input int stl);
    int n = 0;
    logic [31:0] a0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("fetch_req_seen", imem_req, 1);
    a0 = imem_addr;
    chk("valid_low_in_fetch", inst_valid, 0);
    for (int i = 0; i < dly; i++) begin
      @(negedge clk);
      chk("req_held", imem_req, 1);
      chk("addr_held", imem_addr, a0);
      chk("valid_low_wait", inst_valid, 0);
    end
    imem_ready = 1'b1;
    imem_rdata = word;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
    chk("inst_valid", inst_valid, 1);
    chk("inst", inst, word);
    chk("req_low_exec", imem_req, 0);
    if (stl > 0) begin
      stall = 1'b1;
      ctl_jump_register = 1'b1;
      rs_data = 32'h0000_0BAC;
      for (int i = 0; i < stl; i++) begin
        @(negedge clk);
        chk("stall_valid", inst_valid, 1);
        chk("stall_pc", pc, a0);
        chk("stall_inst", inst, word);
      end
      stall = 1'b0;
    end
    {ctl_halted, ctl_jump_register, ctl_jump, ctl_branch} = ctl;
    rs_data = rs;
    if (!ctl[3]) exp_q.push_back(nxt);
    @(negedge clk);
    {ctl_halted, ctl_jump_register, ctl_jump, ctl_branch} = 4'b0000;
    rs_data = '0;
    chk("pc_next", pc, nxt);
  endtask

  initial begin
    int cnt;
    int guard;
    #1 rst_b = 1'b0;
    exp_q.push_back(32'h0);
    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", inst_valid, 0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_halted", halted, 0);
    chk("rst_timeout", fetch_timeout, 0);
    rst_b = 1'b1;
    #1 chk("idle_req", imem_req, 0);
    @(negedge clk);
    chk("fetch_after_idle", imem_req, 1);

    exec_instr(32'h0000_0000, 4'b0000, 32'h0,         32'h0000_0004, 0, 0);
    exec_instr(32'h0000_0000, 4'b0100, 32'h10,        32'h0000_0010, 0, 0);
    exec_instr(32'h0000_FFFE, 4'b0001, 32'h0,         32'h0000_000C, 0, 0);
    exec_instr(32'h0000_0000, 4'b0100, 32'h10,        32'h0000_0010, 0, 0);
    exec_instr(32'h0000_0003, 4'b0001, 32'h0,         32'h0000_0020, 0, 0);
    exec_instr(32'h0000_0000, 4'b0100, 32'hF000_0000, 32'hF000_0000, 0, 0);
    exec_instr(32'h0000_0010, 4'b0010, 32'h0,         32'hF000_0040, 0, 0);
    exec_instr(32'h0000_0010, 4'b0011, 32'h0,         32'hF000_0040, 0, 0);
    exec_instr(32'h0000_0000, 4'b0100, 32'h0000_1003, 32'h0000_1000, 0, 0);
    exec_instr(32'h0000_0000, 4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 0, 0);
    exec_instr(32'h0000_0000, 4'b0000, 32'h0,         32'h0000_0000, 3, 0);
    exec_instr(32'h1234_5678, 4'b0000, 32'h0,         32'h0000_0004, 0, 2);
    exec_instr(32'h0000_0000, 4'b0111, 32'h0000_0200, 32'h0000_0200, 0, 0);
    exec_instr(32'h0000_0010, 4'b1111, 32'h0000_0300, 32'h0000_0200, 0, 0);

    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("halt_flag", halted, 1);
      chk("halt_req", imem_req, 0);
      chk("halt_valid", inst_valid, 0);
      chk("halt_pc", pc, 32'h0000_0200);
      @(negedge clk);
    end
    imem_ready = 1'b0;

    // Reset out of HALT, then reset again in the middle of a fetch.
    rst_b = 1'b0;
    #1 chk("halt_cleared", halted, 0);
    exp_q.push_back(32'h0);
    @(negedge clk);
    rst_b = 1'b1;
    repeat (4) @(negedge clk);
    chk("midfetch_req", imem_req, 1);
    #2 rst_b = 1'b0;
    #1;
    chk("mid_rst_req", imem_req, 0);
    chk("mid_rst_pc", pc, 32'h0);
    chk("mid_rst_inst", inst, 32'h0);
    chk("mid_rst_valid", inst_valid, 0);
    exp_q.push_back(32'h0);
    @(negedge clk);
    rst_b = 1'b1;

    // Fetch that never completes.
    cnt = 0;
    guard = 0;
    @(negedge clk);
    while (!fetch_timeout && guard < 400) begin
      if (imem_req) cnt++;
      @(negedge clk);
      guard++;
    end
    chk("timeout_wait", cnt, 255);
    imem_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("timeout_sticky", fetch_timeout, 1);
      chk("error_req", imem_req, 0);
      chk("error_valid", inst_valid, 0);
      @(negedge clk);
    end
    imem_ready = 1'b0;
    chk("sb_empty", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", tot, bad);
    $finish;
  end

endmodule
